// File: rtl/ofs_plat_shim_ccip_wr_tag_alloc_if.sv
// rtl/ofs_plat_shim_ccip_wr_tag_alloc_if.sv - request/response bundle between AFU, tag allocator and FIU side
interface ofs_plat_shim_ccip_wr_tag_alloc_if #(
    parameter int MDATA_WIDTH = 16
);
    logic                   afu_wr_valid;
    logic                   afu_wr_sop;
    logic [MDATA_WIDTH-1:0] afu_wr_mdata;
    logic                   afu_wr_almfull;
    logic                   fiu_wr_valid;
    logic [MDATA_WIDTH-1:0] fiu_wr_mdata;
    logic                   fiu_almfull;
    logic                   fiu_rsp_valid;
    logic [MDATA_WIDTH-1:0] fiu_rsp_mdata;
    logic                   afu_rsp_valid;
    logic [MDATA_WIDTH-1:0] afu_rsp_mdata;
    logic                   error;

    modport master (
        output afu_wr_valid, afu_wr_sop, afu_wr_mdata, fiu_almfull, fiu_rsp_valid, fiu_rsp_mdata,
        input  afu_wr_almfull, fiu_wr_valid, fiu_wr_mdata, afu_rsp_valid, afu_rsp_mdata, error
    );

    modport slave (
        input  afu_wr_valid, afu_wr_sop, afu_wr_mdata, fiu_almfull, fiu_rsp_valid, fiu_rsp_mdata,
        output afu_wr_almfull, fiu_wr_valid, fiu_wr_mdata, afu_rsp_valid, afu_rsp_mdata, error
    );
endinterface

// File: rtl/ofs_plat_shim_ccip_wr_tag_alloc.sv
// rtl/ofs_plat_shim_ccip_wr_tag_alloc.sv - unique write tag allocator with mdata save/restore
module ofs_plat_shim_ccip_wr_tag_alloc #(
    parameter int MAX_ACTIVE_WR_REQS = 128,
    parameter int MDATA_WIDTH        = 16,
    parameter int ALM_FULL_THRESHOLD = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    ofs_plat_shim_ccip_wr_tag_alloc_if.slave   bus
);
    localparam int N  = MAX_ACTIVE_WR_REQS;
    localparam int TB = $clog2(N);
    localparam int CW = TB + 1;
    localparam logic [CW-1:0] C_LAST_INIT = CW'(N - 1);
    localparam logic [CW-1:0] C_THRESH    = CW'(ALM_FULL_THRESHOLD);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_init_cnt;
    logic [CW-1:0]          r_free_cnt;
    logic [TB-1:0]          r_rd_ptr;
    logic [TB-1:0]          r_wr_ptr;
    logic [TB-1:0]          r_cur_tag;
    logic [N-1:0]           r_busy;
    logic                   r_free_pend;
    logic [TB-1:0]          r_free_tag;
    logic [TB-1:0]          r_fifo [N];
    logic [MDATA_WIDTH-1:0] r_ram  [N];

    logic                   r_afu_wr_almfull;
    logic                   r_fiu_wr_valid;
    logic [MDATA_WIDTH-1:0] r_fiu_wr_mdata;
    logic                   r_afu_rsp_valid;
    logic [MDATA_WIDTH-1:0] r_afu_rsp_mdata;
    logic                   r_error;

    logic                   w_run;
    logic                   w_sop;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_alloc_err;
    logic [TB-1:0]          w_head;
    logic [TB-1:0]          w_wr_tag;
    logic [TB-1:0]          w_rsp_tag;
    logic                   w_rsp;
    logic                   w_rsp_busy;
    logic                   w_free_ok;
    logic                   w_free_err;
    logic                   w_init_wr;
    logic                   w_push;
    logic [TB-1:0]          w_push_tag;
    logic [N-1:0]           w_busy_nxt;
    logic                   w_unused_rsp_hi;

    assign w_run       = (r_state == ST_RUN);
    assign w_sop       = bus.afu_wr_valid && bus.afu_wr_sop;
    assign w_empty     = (r_free_cnt == '0);
    assign w_pop       = w_sop && w_run && !w_empty;
    // The free list is not usable until init has filled it, so an early sop counts as an empty allocation.
    assign w_alloc_err = w_sop && (!w_run || w_empty);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_wr_tag    = w_sop ? w_head : r_cur_tag;

    assign w_rsp_tag   = bus.fiu_rsp_mdata[TB-1:0];
    assign w_rsp       = bus.fiu_rsp_valid && w_run;
    assign w_rsp_busy  = r_busy[w_rsp_tag];
    assign w_free_ok   = w_rsp && w_rsp_busy;
    assign w_free_err  = w_rsp && !w_rsp_busy;

    assign w_init_wr   = (r_state == ST_INIT);
    assign w_push      = w_init_wr || r_free_pend;
    assign w_push_tag  = w_init_wr ? r_init_cnt[TB-1:0] : r_free_tag;

    assign w_unused_rsp_hi = ^bus.fiu_rsp_mdata[MDATA_WIDTH-1:TB];

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_free_ok) begin
            w_busy_nxt[w_rsp_tag] = 1'b0;
        end
        if (w_pop) begin
            w_busy_nxt[w_head] = 1'b1;
        end
    end

    // Free-list and mdata storage carry no reset so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_push_tag;
            end
            if (w_pop) begin
                r_ram[w_head] <= bus.afu_wr_mdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_INIT;
            r_init_cnt       <= '0;
            r_free_cnt       <= '0;
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_cur_tag        <= '0;
            r_busy           <= '0;
            r_free_pend      <= 1'b0;
            r_free_tag       <= '0;
            r_afu_wr_almfull <= 1'b1;
            r_fiu_wr_valid   <= 1'b0;
            r_fiu_wr_mdata   <= '0;
            r_afu_rsp_valid  <= 1'b0;
            r_afu_rsp_mdata  <= '0;
            r_error          <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_cnt       <= r_init_cnt + 1'b1;
                r_afu_wr_almfull <= 1'b1;
                if (r_init_cnt == C_LAST_INIT) begin
                    r_state <= ST_RUN;
                end
            end else begin
                r_afu_wr_almfull <= bus.fiu_almfull || (r_free_cnt <= C_THRESH);
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_free_cnt <= r_free_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_free_cnt <= r_free_cnt - 1'b1;
            end

            if (w_sop) begin
                r_cur_tag <= w_head;
            end
            r_busy <= w_busy_nxt;

            r_fiu_wr_valid <= bus.afu_wr_valid;
            r_fiu_wr_mdata <= {bus.afu_wr_mdata[MDATA_WIDTH-1:TB], w_wr_tag};

            // The tag returns to the free list one cycle after the response, so it is never reissued too early.
            r_afu_rsp_valid <= w_free_ok;
            r_afu_rsp_mdata <= r_ram[w_rsp_tag];
            r_free_pend     <= w_free_ok;
            r_free_tag      <= w_rsp_tag;

            if (w_alloc_err || w_free_err) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.afu_wr_almfull = r_afu_wr_almfull;
    assign bus.fiu_wr_valid   = r_fiu_wr_valid;
    assign bus.fiu_wr_mdata   = r_fiu_wr_mdata;
    assign bus.afu_rsp_valid  = r_afu_rsp_valid;
    assign bus.afu_rsp_mdata  = r_afu_rsp_mdata;
    assign bus.error          = r_error;
endmodule

// File: tb/tb_ofs_plat_shim_ccip_wr_tag_alloc.sv
// tb/tb_ofs_plat_shim_ccip_wr_tag_alloc.sv - scoreboard bench for the write tag allocator
module tb_ofs_plat_shim_ccip_wr_tag_alloc;
    localparam int N   = 128;
    localparam int MW  = 16;
    localparam int TB  = 7;
    localparam int THR = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ofs_plat_shim_ccip_wr_tag_alloc_if #(.MDATA_WIDTH(MW)) bus ();

    ofs_plat_shim_ccip_wr_tag_alloc #(
        .MAX_ACTIVE_WR_REQS(N),
        .MDATA_WIDTH(MW),
        .ALM_FULL_THRESHOLD(THR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [MW-1:0] md;
        logic [MW-1:0] mask;
    } exp_t;

    int            errors = 0;
    int            checks = 0;
    exp_t          wr_q[$];
    logic [MW-1:0] rsp_q[$];
    int            free_q[$];
    int            out_tags[$];
    logic [MW-1:0] m_ram [N];
    bit            m_busy [N];
    logic [TB-1:0] m_cur;
    int            init_left;
    bit            pend_v;
    int            pend_tag;
    bit            m_err;
    logic [MW-1:0] full_mask = '1;
    logic [MW-1:0] hi_mask   = {{(MW-TB){1'b1}}, {TB{1'b0}}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        wr_q.delete();
        rsp_q.delete();
        free_q.delete();
        out_tags.delete();
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_cur     = '0;
        pend_v    = 1'b0;
        pend_tag  = 0;
        m_err     = 1'b0;
        init_left = N;
    endtask

    // Called just after a posedge; asserts reset asynchronously and releases it after a few edges.
    task automatic reset_dut();
        reset = 1'b1;
        #1;
        model_clear();
        check("rst_almfull", bus.afu_wr_almfull, 1);
        check("rst_fiu_valid", bus.fiu_wr_valid, 0);
        check("rst_fiu_mdata", bus.fiu_wr_mdata, 0);
        check("rst_rsp_valid", bus.afu_rsp_valid, 0);
        check("rst_rsp_mdata", bus.afu_rsp_mdata, 0);
        check("rst_error", bus.error, 0);
        check("rst_free_cnt", dut.r_free_cnt, 0);
        bus.afu_wr_valid  = 1'b0;
        bus.afu_wr_sop    = 1'b0;
        bus.afu_wr_mdata  = '0;
        bus.fiu_almfull   = 1'b0;
        bus.fiu_rsp_valid = 1'b0;
        bus.fiu_rsp_mdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic cyc(input bit v, input bit sop, input logic [MW-1:0] md,
                       input bit rv, input logic [MW-1:0] rmd, input bit falm);
        int            pre_cnt;
        int            t;
        bit            exp_alm;
        bit            exp_rv;
        logic [TB-1:0] rt;
        logic [TB-1:0] tt;
        exp_t          e;
        logic [MW-1:0] er;
        bus.afu_wr_valid  = v;
        bus.afu_wr_sop    = sop;
        bus.afu_wr_mdata  = md;
        bus.fiu_rsp_valid = rv;
        bus.fiu_rsp_mdata = rmd;
        bus.fiu_almfull   = falm;
        exp_rv  = 1'b0;
        pre_cnt = free_q.size();
        if (init_left > 0) begin
            exp_alm = 1'b1;
            free_q.push_back(N - init_left);
            init_left--;
        end else begin
            exp_alm = falm || (pre_cnt <= THR);
            if (v && sop) begin
                if (pre_cnt == 0) begin
                    m_err = 1'b1;
                    wr_q.push_back('{md: md, mask: hi_mask});
                end else begin
                    t  = free_q.pop_front();
                    tt = t[TB-1:0];
                    m_busy[t] = 1'b1;
                    m_ram[t]  = md;
                    m_cur     = tt;
                    out_tags.push_back(t);
                    wr_q.push_back('{md: {md[MW-1:TB], tt}, mask: full_mask});
                end
            end else if (v) begin
                wr_q.push_back('{md: {md[MW-1:TB], m_cur}, mask: full_mask});
            end
            if (pend_v) free_q.push_back(pend_tag);
            pend_v = 1'b0;
            if (rv) begin
                rt = rmd[TB-1:0];
                if (m_busy[rt]) begin
                    m_busy[rt] = 1'b0;
                    rsp_q.push_back(m_ram[rt]);
                    exp_rv   = 1'b1;
                    pend_v   = 1'b1;
                    pend_tag = int'(rt);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("almfull", bus.afu_wr_almfull, exp_alm);
        check("free_cnt", dut.r_free_cnt, free_q.size());
        check("error", bus.error, m_err);
        check("fiu_wr_valid", bus.fiu_wr_valid, v);
        if (v && wr_q.size() > 0) begin
            e = wr_q.pop_front();
            check("fiu_wr_mdata", bus.fiu_wr_mdata & e.mask, e.md & e.mask);
        end
        check("afu_rsp_valid", bus.afu_rsp_valid, exp_rv);
        if (exp_rv && rsp_q.size() > 0) begin
            er = rsp_q.pop_front();
            check("afu_rsp_mdata", bus.afu_rsp_mdata, er);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, '0, 0);
    endtask

    function automatic logic [MW-1:0] rsp_md(input int tag);
        logic [MW-1:0] r;
        logic [TB-1:0] t;
        r = MW'($urandom);
        t = tag[TB-1:0];
        return {r[MW-1:TB], t};
    endfunction

    initial begin
        int            tg;
        int            freed;
        logic [MW-1:0] md;

        bus.afu_wr_valid  = 1'b0;
        bus.afu_wr_sop    = 1'b0;
        bus.afu_wr_mdata  = '0;
        bus.fiu_almfull   = 1'b0;
        bus.fiu_rsp_valid = 1'b0;
        bus.fiu_rsp_mdata = '0;
        @(posedge clk);
        reset_dut();

        // Init fill, then almfull drops once the list is full.
        idle(N);
        check("init_free_cnt", dut.r_free_cnt, N);
        check("init_almfull_hi", bus.afu_wr_almfull, 1);
        idle(1);
        check("run_almfull_lo", bus.afu_wr_almfull, 0);

        // Single-beat write and its response.
        cyc(1, 1, 16'hABCD, 0, '0, 0);
        check("t2_fiu_mdata", bus.fiu_wr_mdata, 16'hAB80);
        idle(1);
        cyc(0, 0, '0, 1, 16'h0000, 0);
        check("t2_rsp_mdata", bus.afu_rsp_mdata, 16'hABCD);
        idle(1);
        check("t2_free_back", dut.r_free_cnt, N);

        // Four-beat packet shares one tag.
        cyc(1, 1, 16'h1234, 0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, MW'($urandom), 0, '0, 0);
        check("t3_free_drop", dut.r_free_cnt, N - 1);
        tg = out_tags[out_tags.size() - 1];
        cyc(0, 0, '0, 1, rsp_md(tg), 0);
        check("t3_rsp_mdata", bus.afu_rsp_mdata, 16'h1234);
        idle(2);

        // Drain the free list completely, with occasional downstream almfull.
        for (int i = 0; i < 120; i++) cyc(1, 1, MW'($urandom), 0, '0, (i % 37) == 5);
        check("t4_cnt_8", dut.r_free_cnt, 8);
        for (int i = 0; i < 8; i++) cyc(1, 1, MW'($urandom), 0, '0, 0);
        check("t4_cnt_0", dut.r_free_cnt, 0);
        check("t4_no_err", bus.error, 0);
        cyc(1, 1, 16'h5A5A, 0, '0, 0);
        check("t4_err_set", bus.error, 1);
        idle(3);
        check("t4_err_sticky", bus.error, 1);

        // Reset with requests pending, then re-init.
        reset_dut();
        idle(N + 1);

        // Simultaneous pop and push at five free tags.
        for (int i = 0; i < N - 5; i++) cyc(1, 1, MW'($urandom), 0, '0, 0);
        check("t5_cnt_5", dut.r_free_cnt, 5);
        freed = out_tags[0];
        cyc(0, 0, '0, 1, rsp_md(freed), 0);
        cyc(1, 1, MW'($urandom), 0, '0, 0);
        check("t5_cnt_same", dut.r_free_cnt, 5);
        for (int i = 0; i < 5; i++) cyc(1, 1, MW'($urandom), 0, '0, 0);
        check("t5_tail_tag", bus.fiu_wr_mdata[TB-1:0], freed);
        check("t5_cnt_0", dut.r_free_cnt, 0);

        // Double free of tag 5.
        cyc(0, 0, '0, 1, 16'h0005, 0);
        check("t6_first_free_ok", bus.error, 0);
        cyc(0, 0, '0, 1, 16'h0005, 0);
        check("t6_double_err", bus.error, 1);
        idle(2);
        check("t6_cnt_unchanged", dut.r_free_cnt, 1);

        // Mid-stream reset clears error and restarts the fill.
        md = 16'hC3C3;
        bus.afu_wr_valid  = 1'b1;
        bus.afu_wr_sop    = 1'b1;
        bus.afu_wr_mdata  = md;
        bus.fiu_rsp_valid = 1'b1;
        bus.fiu_rsp_mdata = 16'h0011;
        reset_dut();
        idle(N);
        check("t6_reinit_cnt", dut.r_free_cnt, N);
        idle(1);
        cyc(1, 1, 16'hFFFF, 0, '0, 0);
        check("t6_first_tag", bus.fiu_wr_mdata, 16'hFF80);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ofs_plat_shim_ccip_wr_tag_alloc.md
Name: ofs_plat_shim_ccip_wr_tag_alloc

Overview:
- Upstream stage of the c1 write-response EOP detector.
- Rewrites the low log2(MAX_ACTIVE_WR_REQS) bits of each write request's mdata with a unique tag taken from a free list, which guarantees the unique-tag property the EOP detector depends on.
- Saves the AFU's original mdata per tag, restores it on the single packed write response, then returns the tag to the free list.
- Throttles the AFU through almost-full when tags run low.

Parameters:
- MAX_ACTIVE_WR_REQS, 128, number of tags; must be a power of 2, >= 4. N_TAG_BITS = log2 of this.
- MDATA_WIDTH, 16, width of the mdata field.
- ALM_FULL_THRESHOLD, 8, AFU almost-full asserts when free tags <= this value.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- afu_wr_valid  in  1  write request beat from AFU
- afu_wr_sop  in  1  first beat of a multi-beat packet
- afu_wr_mdata  in  MDATA_WIDTH  AFU mdata
- afu_wr_almfull  out  1  almost-full to AFU
- fiu_wr_valid  out  1  write request beat toward EOP detector/FIU
- fiu_wr_mdata  out  MDATA_WIDTH  {afu_wr_mdata[MDATA_WIDTH-1:N_TAG_BITS], tag}
- fiu_almfull  in  1  downstream almost-full
- fiu_rsp_valid  in  1  packed write response (exactly one per packet)
- fiu_rsp_mdata  in  MDATA_WIDTH  response mdata; low N_TAG_BITS carry the tag
- afu_rsp_valid  out  1  write response to AFU
- afu_rsp_mdata  out  MDATA_WIDTH  restored original mdata
- error  out  1  sticky: allocation with empty free list, or double free

Behaviour:
- Reset (async assert): all outputs 0 except afu_wr_almfull=1; free count=0; init counter=0; error=0.
- Init state: on the first clk after reset deasserts, write tags 0..N-1 into the free-list FIFO, one per cycle, over N cycles. During init, afu_wr_almfull=1. A response arriving during init is dropped and not freed.
- Run state: afu_wr_almfull = fiu_almfull || (free_cnt <= ALM_FULL_THRESHOLD), registered (1 cycle).
- Request path, latency 1 cycle:
  - On valid&&sop: pop the free-list head, latch it as cur_tag, and write afu_wr_mdata to the mdata RAM at that tag.
  - On valid&&!sop: reuse cur_tag; no pop, no RAM write.
  - fiu_wr_valid/fiu_wr_mdata are registered copies with the tag substituted.
- Response path, latency 1 cycle:
  - fiu_rsp_valid reads the mdata RAM at the tag.
  - Next cycle: afu_rsp_valid=1, afu_rsp_mdata=saved value, and the tag is pushed to the free-list tail.
- Simultaneous pop and push in one cycle: free_cnt unchanged. A tag freed in cycle t is not allocatable before t+2.
- Free-list FIFO: N entries, pointers wrap modulo N, free_cnt is N_TAG_BITS+1 bits wide, range 0..N.
- Empty free list on sop: set error. fiu_wr_mdata carries an undefined tag; the beat is still forwarded.
- Double free: a per-tag busy bit is set on alloc and cleared on free. A free of a non-busy tag sets error and does not push.
- Mid-operation reset: clears all state. In-flight responses are lost, and the reset must come from the system reset.
- Other header fields bypass this block externally, aligned by the same 1-cycle register.

Test Plan:
1. Reset, then 128 idle cycles -> afu_wr_almfull=1 during init, 0 on the cycle after init completes with fiu_almfull=0; free_cnt=128.
2. Single-beat sop with mdata=0xABCD -> next cycle fiu_wr_mdata=0xAB80 (tag 0x00, N=128). Response mdata=0x0000 -> one cycle later afu_rsp_mdata=0xABCD; free_cnt back to 128.
3. 4-beat packet, sop beat mdata=0x1234 -> all 4 fiu beats carry the same tag; free_cnt drops by exactly 1. A single packed response restores 0x1234.
4. Issue 120 sop requests with no responses -> afu_wr_almfull rises when free_cnt=8. Issue 8 more -> free_cnt=0, error=0. Issue a 129th sop -> error=1 and stays 1.
5. Same-cycle sop alloc and response free with free_cnt=5 -> free_cnt stays 5; the freed tag appears at the FIFO tail.
6. Response with tag 0x05 when tag 5 is not outstanding -> error=1, free_cnt unchanged. Assert reset mid-stream -> error=0, re-init over 128 cycles.
